adc_window_cmp: RTL



---
 rtl/adc_window_cmp_if.sv | 15 +
 rtl/adc_window_cmp.sv | 120 ++++++++++++
 2 files changed

// File: rtl/adc_window_cmp_if.sv
// ADC conversion handshake bundle.
//   x   : converter data, valid while eoc=1 after a conversion
//   eoc : end of conversion (1 = idle/done, 0 = converting)
//   soc : start of conversion request to the converter
// master = window comparator (drives soc), slave = converter side.
interface adc_window_cmp_if #(
  parameter int W = 8
);
  logic [W-1:0] x;
  logic         eoc;
  logic         soc;

  modport master (input x, input eoc, output soc);
  modport slave  (output x, output eoc, input soc);
endinterface

// File: rtl/adc_window_cmp.sv
// Sliding-window ADC threshold unit.
// Runs the soc/eoc handshake with an external converter, keeps the last
// DEPTH samples and their running sum, and raises out once the window is
// full and the sum reaches thr.
// Ports:
//   clock, reset_ : system clock, asynchronous active-low reset
//   adc           : converter handshake (x, eoc in; soc out)
//   en            : acquisition enable
//   clr           : synchronous flush of window, sum, flags and FSM
//   thr           : threshold, compared unsigned in S_EVAL
//   thr_lo        : release threshold (only with ADC_WIN_HYST_EN)
//   sum, full, out: window sum, window-full flag, decision
// Optional feature macro: ADC_WIN_HYST_EN (hysteresis on out).
module adc_window_cmp #(
  parameter  int W     = 8,
  parameter  int DEPTH = 3,
  localparam int SW    = W + $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_,
  adc_window_cmp_if.master adc,
  input  logic             en,
  input  logic             clr,
  input  logic [SW-1:0]    thr,
`ifdef ADC_WIN_HYST_EN
  input  logic [SW-1:0]    thr_lo,
`endif
  output logic [SW-1:0]    sum,
  output logic             full,
  output logic             out
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SOC, S_WAIT, S_LOAD, S_EVAL} state_t;

  state_t                  star_q, star_d;
  logic                    soc_q, soc_d;
  logic                    full_q, full_d;
  logic                    out_q, out_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic [DEPTH-1:0][W-1:0] win_q, win_d;   // [0] newest, [DEPTH-1] oldest
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    win_full;
  logic [W-1:0]            oldest;
  logic                    hit;

  assign win_full = (cnt_q == CW'(DEPTH));
  // Until the window has filled, nothing real drops out of it.
  assign oldest   = win_full ? win_q[DEPTH-1] : '0;

`ifdef ADC_WIN_HYST_EN
  // Set at thr, release only below thr_lo, hold inside the band.
  assign hit = (sum_q >= thr) ? 1'b1 : ((sum_q < thr_lo) ? 1'b0 : out_q);
`else
  assign hit = (sum_q >= thr);
`endif

  always_comb begin
    star_d = star_q;
    sum_d  = sum_q;
    win_d  = win_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    out_d  = out_q;
    unique case (star_q)
      S_IDLE: if (en) star_d = S_SOC;
      S_SOC:  if (!adc.eoc) star_d = S_WAIT;
      S_WAIT: if (adc.eoc) star_d = S_LOAD;
      S_LOAD: begin
        win_d  = {win_q[DEPTH-2:0], adc.x};
        sum_d  = sum_q + SW'(adc.x) - SW'(oldest);
        if (!win_full) cnt_d = cnt_q + CW'(1);
        star_d = S_EVAL;
      end
      S_EVAL: begin
        full_d = win_full;
        out_d  = win_full & hit;
        star_d = en ? S_SOC : S_IDLE;
      end
      default: star_d = S_IDLE;
    endcase
    if (clr) begin
      star_d = S_IDLE;
      sum_d  = '0;
      win_d  = '0;
      cnt_d  = '0;
      full_d = 1'b0;
      out_d  = 1'b0;
    end
    // soc is a registered decode of the next state, so it is high
    // exactly for the cycles spent in S_SOC.
    soc_d = (star_d == S_SOC);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star_q <= S_IDLE;
      soc_q  <= 1'b0;
      sum_q  <= '0;
      win_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      star_q <= star_d;
      soc_q  <= soc_d;
      sum_q  <= sum_d;
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      out_q  <= out_d;
    end
  end

  assign adc.soc = soc_q;
  assign sum     = sum_q;
  assign full    = full_q;
  assign out     = out_q;
endmodule
